// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and defaults for the debounce_sync switch/button conditioner.
package debounce_pkg;

    // Per-bit debounce FSM: two settled levels plus a qualifying state toward each.
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } db_state_t;

    // 10 ms hold time at a 100 MHz system clock.
    localparam int DB_TICKS_DEFAULT = 1_000_000;

endpackage

// File: rtl/db_bit.sv
// db_bit: one channel of debounce_sync. Contains a 2-flop synchronizer, the
// settle FSM with its hold counter, and (when DEBOUNCE_SYNC_EDGE_EN is defined)
// registered rise/fall pulses. Without the macro the pulse outputs are tied low.
module db_bit
    import debounce_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);

    // Counter only ever has to reach DB_TICKS-1, so $clog2 bits are enough.
    localparam int              CW      = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DB_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    db_state_t     state_q;
    logic [CW-1:0] cnt_q;
    logic          db_q;

    // Two-stage synchronizer for the asynchronous pin level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Settle FSM: a new level must persist DB_TICKS cycles before db_q follows it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= WAIT_HI;
                        cnt_q   <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!sync2_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        db_q    <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        state_q <= WAIT_LO;
                        cnt_q   <= '0;
                    end
                end
                WAIT_LO: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        db_q    <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                    db_q    <= 1'b0;
                end
            endcase
        end
    end

    assign db_o = db_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
    logic rise_q;
    logic fall_q;
    logic rise_d;
    logic fall_d;

    // The qualifying cycle of a WAIT state is exactly the cycle db_q is about to flip.
    assign rise_d = (state_q == WAIT_HI) && sync2_q  && (cnt_q == CNT_MAX);
    assign fall_d = (state_q == WAIT_LO) && !sync2_q && (cnt_q == CNT_MAX);

    // Edge pulses registered alongside db_q so they coincide with its change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_sync.sv
// debounce_sync: W independent synchronize-and-debounce channels for board
// switches/buttons. Optional edge pulses are enabled by DEBOUNCE_SYNC_EDGE_EN.
module debounce_sync
    import debounce_pkg::*;
#(
    parameter int W        = 8,
    parameter int DB_TICKS = DB_TICKS_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] db_out,
    output logic [W-1:0] rise_tick,
    output logic [W-1:0] fall_tick
);

    // One fully independent channel per input bit.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            db_bit #(
                .DB_TICKS (DB_TICKS)
            ) u_db_bit (
                .clk    (clk),
                .reset  (reset),
                .raw_i  (raw_in[gi]),
                .db_o   (db_out[gi]),
                .rise_o (rise_tick[gi]),
                .fall_o (fall_tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_sync.sv
// tb_debounce_sync: scoreboard bench for debounce_sync with DB_TICKS=4, W=8.
// Stimulus pushes expected output changes (cycle + values); a monitor pops one
// entry every time the DUT outputs change and compares.
module tb_debounce_sync;

    localparam int W   = 8;
    localparam int DBT = 4;
    localparam int LAT = DBT + 3;

`ifdef DEBOUNCE_SYNC_EDGE_EN
    localparam logic [W-1:0] TICK_EN = '1;
`else
    localparam logic [W-1:0] TICK_EN = '0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] raw_in = '0;
    logic [W-1:0] db_out;
    logic [W-1:0] rise_tick;
    logic [W-1:0] fall_tick;

    debounce_sync #(
        .W        (W),
        .DB_TICKS (DBT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .db_out    (db_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           ecyc;
        logic [W-1:0] db;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Queue the change expected at posedge number c; with edge pulses enabled
    // a second change (pulses dropping) follows one cycle later.
    task automatic push_exp(input int c, input logic [W-1:0] db,
                            input logic [W-1:0] r, input logic [W-1:0] f);
        exp_t e;
        e = '{ecyc: c, db: db, rise: r & TICK_EN, fall: f & TICK_EN};
        sb_q.push_back(e);
        if (((r | f) & TICK_EN) != '0) begin
            e = '{ecyc: c + 1, db: db, rise: '0, fall: '0};
            sb_q.push_back(e);
        end
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (db_out !== '0) begin
            errors++;
            $display("FAIL %s db_out got=%h required=00", name, db_out);
        end else $display("ok   %s db_out=%h", name, db_out);
        checks++;
        if (rise_tick !== '0) begin
            errors++;
            $display("FAIL %s rise_tick got=%h required=00", name, rise_tick);
        end
        checks++;
        if (fall_tick !== '0) begin
            errors++;
            $display("FAIL %s fall_tick got=%h required=00", name, fall_tick);
        end
    endtask

    // Monitor: any change of outputs outside reset is one transaction.
    logic [3*W-1:0] mon_prev = '0;
    logic [3*W-1:0] mon_cur;
    exp_t           mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_cur = {db_out, rise_tick, fall_tick};
            if (!reset) begin
                mon_prev = mon_cur;
            end else if (mon_cur !== mon_prev) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got db=%h rise=%h fall=%h required no change",
                             cyc, db_out, rise_tick, fall_tick);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.ecyc != cyc || mon_e.db !== db_out ||
                        mon_e.rise !== rise_tick || mon_e.fall !== fall_tick) begin
                        errors++;
                        $display("FAIL event got cyc=%0d db=%h rise=%h fall=%h required cyc=%0d db=%h rise=%h fall=%h",
                                 cyc, db_out, rise_tick, fall_tick,
                                 mon_e.ecyc, mon_e.db, mon_e.rise, mon_e.fall);
                    end else begin
                        $display("ok   event cyc=%0d db=%h rise=%h fall=%h",
                                 cyc, db_out, rise_tick, fall_tick);
                    end
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        int c;

        // Reset held with all inputs high: outputs must stay clear.
        reset  = 1'b0;
        raw_in = 8'hFF;
        repeat (3) @(negedge clk);
        #1 check_reset("rst_hold");

        // Release with inputs already high: full rise after DBT+3 edges.
        @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push_exp(c + LAT, 8'hFF, 8'hFF, 8'h00);
        repeat (12) @(negedge clk);

        // All bits fall together.
        raw_in = 8'h00;
        c = cyc;
        push_exp(c + LAT, 8'h00, 8'h00, 8'hFF);
        repeat (12) @(negedge clk);

        // Single bit 0 rise, others untouched.
        raw_in = 8'h01;
        c = cyc;
        push_exp(c + LAT, 8'h01, 8'h01, 8'h00);
        repeat (12) @(negedge clk);

        // Bit 3 bounces every 2 cycles, then settles high.
        raw_in = 8'h09;
        repeat (2) @(negedge clk);
        raw_in = 8'h01;
        repeat (2) @(negedge clk);
        raw_in = 8'h09;
        repeat (2) @(negedge clk);
        raw_in = 8'h01;
        repeat (2) @(negedge clk);
        raw_in = 8'h09;
        c = cyc;
        push_exp(c + LAT, 8'h09, 8'h08, 8'h00);
        repeat (12) @(negedge clk);

        // Back to zero, then a multi-bit pattern in one step, then back.
        raw_in = 8'h00;
        c = cyc;
        push_exp(c + LAT, 8'h00, 8'h00, 8'h09);
        repeat (12) @(negedge clk);
        raw_in = 8'hA5;
        c = cyc;
        push_exp(c + LAT, 8'hA5, 8'hA5, 8'h00);
        repeat (12) @(negedge clk);
        raw_in = 8'h00;
        c = cyc;
        push_exp(c + LAT, 8'h00, 8'h00, 8'hA5);
        repeat (12) @(negedge clk);

        // Reset while bit 0 counter sits at 2; release forces a fresh full hold.
        raw_in = 8'h01;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1 check_reset("rst_mid_wait");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        c = cyc;
        push_exp(c + LAT, 8'h01, 8'h01, 8'h00);
        repeat (12) @(negedge clk);

        // Asynchronous clear while db_out is high, mid-cycle.
        reset = 1'b0;
        #1 check_reset("rst_async");
        raw_in = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);

        // Every queued change must have been observed.
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events got=%0d required=0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
